// File: rtl/uart_line_editor_pkg.sv
// Shared character codes, FSM state encoding and handshake helper for the UART line editor.
package uart_line_editor_pkg;

    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_DEL    = 8'h7F;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_BEL    = 8'h07;
    localparam logic [7:0] CH_PROMPT = 8'h3E;

    typedef enum logic [3:0] {
        S_PROMPT_REQ,
        S_PROMPT_ACK,
        S_IDLE,
        S_ECHO_REQ,
        S_ECHO_ACK,
        S_BS_REQ,
        S_BS_ACK,
        S_NL_REQ,
        S_NL_ACK,
        S_REPLAY_REQ,
        S_REPLAY_ACK
    } state_e;

    function automatic logic is_erase(input logic [7:0] c);
        return (c == CH_BS) || (c == CH_DEL);
    endfunction

    // Each request state has a matching acknowledge state.
    function automatic state_e req_to_ack(input state_e s);
        case (s)
            S_PROMPT_REQ: return S_PROMPT_ACK;
            S_ECHO_REQ:   return S_ECHO_ACK;
            S_BS_REQ:     return S_BS_ACK;
            S_NL_REQ:     return S_NL_ACK;
            S_REPLAY_REQ: return S_REPLAY_ACK;
            default:      return S_PROMPT_REQ;
        endcase
    endfunction

endpackage

// File: rtl/uart_line_editor_line_ram.sv
// Line buffer: synchronous write, two asynchronous read ports (replay and downstream), no reset on contents.
module uart_line_editor_line_ram #(
    parameter int unsigned LINE_MAX = 32,
    parameter int unsigned AW       = 5
) (
    input  logic          clk_50m,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [7:0]    ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [7:0]    rb_data
);

    logic [7:0] mem_q [LINE_MAX];

    always_ff @(posedge clk_50m) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];

endmodule

// File: rtl/uart_line_editor.sv
// Console line editor between UART rx and tx: echo, backspace, bell on full line,
// CR replays the line and publishes it through a read port with a done strobe.
module uart_line_editor
    import uart_line_editor_pkg::*;
#(
    parameter int unsigned LINE_MAX = 32,
    parameter int unsigned AW       = 5,
    parameter logic [7:0]  PROMPT   = CH_PROMPT
) (
    input  logic          clk_50m,
    input  logic          rst,
    input  logic          rx_rdy,
    input  logic [7:0]    rx_data,
    input  logic          tx_rdy,
    output logic          tx_en,
    output logic [7:0]    tx_data,
    output logic          line_done,
    output logic [AW:0]   line_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          overrun
);

    localparam int unsigned WW = AW + 1;
    localparam int unsigned IW = AW + 2;
    localparam logic [WW-1:0] WP_FULL = WW'(LINE_MAX);

    state_e        state_q, state_d;
    logic [WW-1:0] wp_q, wp_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    char_q, char_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          line_done_q, line_done_d;
    logic [WW-1:0] line_len_q, line_len_d;
    logic          overrun_q, overrun_d;

    logic          we_c;
    logic          consume_c;
    logic [7:0]    seq_byte_c;
    logic [7:0]    rep_data_c;
    logic [IW-1:0] idx_wp_c;

    uart_line_editor_line_ram #(
        .LINE_MAX (LINE_MAX),
        .AW       (AW)
    ) u_line_ram (
        .clk_50m (clk_50m),
        .we      (we_c),
        .waddr   (wp_q[AW-1:0]),
        .wdata   (hold_q),
        .ra_addr (idx_q[AW-1:0]),
        .ra_data (rep_data_c),
        .rb_addr (rd_addr),
        .rb_data (rd_data)
    );

    assign idx_wp_c = IW'(wp_q);

    // Byte offered to the transmitter in each request state.
    always_comb begin
        seq_byte_c = PROMPT;
        case (state_q)
            S_ECHO_REQ:   seq_byte_c = char_q;
            S_BS_REQ:     seq_byte_c = (idx_q == IW'(1)) ? CH_SP : CH_BS;
            S_NL_REQ:     seq_byte_c = (idx_q == '0) ? CH_CR : CH_LF;
            S_REPLAY_REQ: begin
                if (idx_q < idx_wp_c) begin
                    seq_byte_c = rep_data_c;
                end else if (idx_q == idx_wp_c) begin
                    seq_byte_c = CH_CR;
                end else begin
                    seq_byte_c = CH_LF;
                end
            end
            default: seq_byte_c = PROMPT;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        idx_d       = idx_q;
        char_d      = char_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_en_d     = tx_en_q;
        tx_data_d   = tx_data_q;
        line_done_d = 1'b0;
        line_len_d  = line_len_q;
        overrun_d   = overrun_q;
        we_c        = 1'b0;
        consume_c   = 1'b0;

        case (state_q)
            S_PROMPT_REQ, S_ECHO_REQ, S_BS_REQ, S_NL_REQ, S_REPLAY_REQ: begin
                if (tx_rdy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = seq_byte_c;
                    state_d   = req_to_ack(state_q);
                end
            end
            S_PROMPT_ACK, S_ECHO_ACK: begin
                if (!tx_rdy) begin
                    tx_en_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_BS_ACK: begin
                if (!tx_rdy) begin
                    tx_en_d = 1'b0;
                    if (idx_q == IW'(2)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_BS_REQ;
                    end
                end
            end
            S_NL_ACK: begin
                if (!tx_rdy) begin
                    tx_en_d = 1'b0;
                    if (idx_q == '0) begin
                        idx_d   = IW'(1);
                        state_d = S_NL_REQ;
                    end else begin
                        idx_d   = '0;
                        state_d = (wp_q != '0) ? S_REPLAY_REQ : S_PROMPT_REQ;
                    end
                end
            end
            S_REPLAY_ACK: begin
                if (!tx_rdy) begin
                    tx_en_d = 1'b0;
                    // Last byte of replay is the LF at index wp+1.
                    if (idx_q == idx_wp_c + IW'(1)) begin
                        line_len_d  = wp_q;
                        line_done_d = 1'b1;
                        wp_d        = '0;
                        state_d     = S_PROMPT_REQ;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_REPLAY_REQ;
                    end
                end
            end
            S_IDLE: begin
                if (hold_full_q) begin
                    consume_c = 1'b1;
                    idx_d     = '0;
                    if (hold_q == CH_CR) begin
                        state_d = S_NL_REQ;
                    end else if (is_erase(hold_q)) begin
                        if (wp_q != '0) begin
                            wp_d    = wp_q - WW'(1);
                            state_d = S_BS_REQ;
                        end
                    end else if (hold_q != CH_LF) begin
                        if (wp_q < WP_FULL) begin
                            we_c    = 1'b1;
                            wp_d    = wp_q + WW'(1);
                            char_d  = hold_q;
                        end else begin
                            char_d  = CH_BEL;
                        end
                        state_d = S_ECHO_REQ;
                    end
                end
            end
            default: state_d = S_PROMPT_REQ;
        endcase

        // One-byte rx holding register; a byte arriving while it is full is lost.
        if (rx_rdy) begin
            if (!hold_full_q || consume_c) begin
                hold_d      = rx_data;
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume_c) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q     <= S_PROMPT_REQ;
            wp_q        <= '0;
            idx_q       <= '0;
            char_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= '0;
            line_done_q <= 1'b0;
            line_len_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            idx_q       <= idx_d;
            char_q      <= char_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
            line_done_q <= line_done_d;
            line_len_q  <= line_len_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx_en     = tx_en_q;
    assign tx_data   = tx_data_q;
    assign line_done = line_done_q;
    assign line_len  = line_len_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_line_editor.sv
// Bench for uart_line_editor: UART transmitter model, queue-based line editing reference, directed and random lines.
module tb_uart_line_editor;

    localparam int unsigned AW       = 5;
    localparam int unsigned LINE_MAX = 32;

    logic          clk_50m;
    logic          rst;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          tx_rdy;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic          line_done;
    logic [AW:0]   line_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          overrun;

    uart_line_editor #(
        .LINE_MAX (LINE_MAX),
        .AW       (AW),
        .PROMPT   (8'h3E)
    ) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .tx_rdy    (tx_rdy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .line_done (line_done),
        .line_len  (line_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .overrun   (overrun)
    );

    initial begin
        clk_50m = 1'b0;
        forever #10 clk_50m = ~clk_50m;
    end

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int unsigned done_lens[$];
    int unsigned exp_lens[$];
    logic [7:0]  line[$];
    logic [7:0]  last_line[$];

    // Transmitter model: accepts a byte on tx_en while idle, then is busy a random 1..4 cycles.
    logic uart_idle;
    logic stall;
    int   busy;
    assign tx_rdy = uart_idle & ~stall;

    always @(negedge clk_50m or posedge rst) begin
        if (rst) begin
            uart_idle = 1'b1;
            busy      = 0;
        end else if (tx_en && tx_rdy) begin
            got.push_back(tx_data);
            uart_idle = 1'b0;
            busy      = int'($urandom_range(1, 4));
        end else if (!uart_idle) begin
            busy = busy - 1;
            if (busy <= 0) uart_idle = 1'b1;
        end
    end

    always @(negedge clk_50m) begin
        if (!rst && line_done) done_lens.push_back(int'(line_len));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: what a terminal should see for each received byte.
    task automatic model_rx(input logic [7:0] c);
        if (c == 8'h0D) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            if (line.size() > 0) begin
                foreach (line[i]) exp_q.push_back(line[i]);
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
                exp_lens.push_back(line.size());
                last_line = line;
                line.delete();
            end
            exp_q.push_back(8'h3E);
        end else if (c == 8'h08 || c == 8'h7F) begin
            if (line.size() > 0) begin
                void'(line.pop_back());
                exp_q.push_back(8'h08);
                exp_q.push_back(8'h20);
                exp_q.push_back(8'h08);
            end
        end else if (c != 8'h0A) begin
            if (line.size() < LINE_MAX) begin
                line.push_back(c);
                exp_q.push_back(c);
            end else begin
                exp_q.push_back(8'h07);
            end
        end
    endtask

    task automatic send_raw(input logic [7:0] c);
        @(negedge clk_50m);
        rx_rdy  = 1'b1;
        rx_data = c;
        @(negedge clk_50m);
        rx_rdy  = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        send_raw(c);
        model_rx(c);
    endtask

    task automatic wait_quiet();
        int cyc = 0;
        while (got.size() < exp_q.size() && cyc < 5000) begin
            @(negedge clk_50m);
            cyc++;
        end
        repeat (20) @(negedge clk_50m);
    endtask

    task automatic send_line(input logic [7:0] s[$]);
        int k = 0;
        while (k < s.size()) begin
            send(s[k]);
            k++;
            if (k < s.size() && $urandom_range(0, 1) == 1) begin
                repeat (2) @(negedge clk_50m);
                send(s[k]);
                k++;
            end
            wait_quiet();
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        chk({tag, "_ndone"}, 32'(done_lens.size()), 32'(exp_lens.size()));
        for (int i = 0; i < exp_lens.size() && i < done_lens.size(); i++)
            chk($sformatf("%s_len%0d", tag, i), done_lens[i], exp_lens[i]);
        chk({tag, "_txen_idle"}, 32'(tx_en), 32'd0);
        got.delete();
        exp_q.delete();
        done_lens.delete();
        exp_lens.delete();
    endtask

    task automatic check_rd(input string tag);
        for (int i = 0; i < last_line.size(); i++) begin
            @(negedge clk_50m);
            rd_addr = AW'(i);
            #1;
            chk($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(last_line[i]));
        end
    endtask

    initial begin
        logic [7:0] s[$];
        int cyc;

        rst     = 1'b1;
        stall   = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        rd_addr = '0;

        repeat (3) @(negedge clk_50m);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
        chk("rst_line_len", 32'(line_len), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        exp_q.push_back(8'h3E);
        rst = 1'b0;
        wait_quiet();
        check_stream("prompt");

        s = '{8'h61, 8'h62, 8'h63, 8'h0D};
        send_line(s);
        check_stream("abc");
        chk("abc_line_len", 32'(line_len), 32'd3);
        check_rd("abc");

        s = '{8'h61, 8'h62, 8'h08, 8'h63, 8'h0D};
        send_line(s);
        check_stream("ab_bs_c");
        chk("ab_bs_c_line_len", 32'(line_len), 32'd2);
        check_rd("ab_bs_c");

        s = '{8'h08, 8'h0D};
        send_line(s);
        check_stream("empty_line");

        s.delete();
        for (int i = 0; i < 33; i++) s.push_back(8'(8'h41 + i));
        s.push_back(8'h0D);
        send_line(s);
        check_stream("full_line");
        chk("full_line_len", 32'(line_len), 32'd32);
        chk("full_overrun", 32'(overrun), 32'd0);
        check_rd("full");

        for (int n = 0; n < 6; n++) begin
            int len;
            int r;
            s.delete();
            len = int'($urandom_range(0, 40));
            for (int i = 0; i < len; i++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      s.push_back(8'h08);
                else if (r == 1) s.push_back(8'h7F);
                else if (r == 2) s.push_back(8'h0A);
                else             s.push_back(8'($urandom_range(33, 126)));
            end
            s.push_back(8'h0D);
            send_line(s);
            check_stream($sformatf("rand%0d", n));
            check_rd($sformatf("rand%0d", n));
        end
        chk("rand_overrun", 32'(overrun), 32'd0);

        // Transmitter stalled: first byte consumed, second held, third lost.
        @(negedge clk_50m);
        stall = 1'b1;
        send_raw(8'h78);
        send_raw(8'h79);
        chk("ovr_after_held", 32'(overrun), 32'd0);
        send_raw(8'h7A);
        chk("ovr_after_drop", 32'(overrun), 32'd1);
        repeat (5) @(negedge clk_50m);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        stall = 1'b0;
        cyc = 0;
        while (!tx_en && cyc < 50) begin
            @(negedge clk_50m);
            cyc++;
        end
        chk("ovr_tx_en_seen", 32'(tx_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx_en", 32'(tx_en), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_line_done", 32'(line_done), 32'd0);
        repeat (3) @(negedge clk_50m);
        got.delete();
        exp_q.delete();
        done_lens.delete();
        exp_lens.delete();
        line.delete();
        exp_q.push_back(8'h3E);
        rst = 1'b0;
        wait_quiet();
        check_stream("after_rst");

        s = '{8'h71, 8'h0D};
        send_line(s);
        check_stream("after_rst_line");
        chk("after_rst_len", 32'(line_len), 32'd1);
        check_rd("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
